mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM stage of the five-stage pipeline. It consumes the EX/MEM pipeline register outputs and produces the write-back bundle for MEM/WB.
- Non-memory instructions pass straight through.
- Loads and stores run a request/acknowledge transaction on the data bus. The stage stalls the pipeline through the ctrl unit until the transaction completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wd_i  in  5  destination register address
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result
- hi_i  in  32  HI value
- lo_i  in  32  LO value
- whilo_i  in  1  HI/LO write enable
- aluop_i  in  8  operation code, `EXE_*_OP encodings
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data
- stall  in  6  ctrl stall vector
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- hi_o  out  32  to MEM/WB
- lo_o  out  32  to MEM/WB
- whilo_o  out  1  to MEM/WB
- stallreq_o  out  1  stall request to ctrl
- misalign_o  out  1  alignment fault flag
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  bus write enable
- dbus_addr_o  out  32  word address; bits [1:0] forced to 00
- dbus_sel_o  out  4  byte-lane select
- dbus_wdata_o  out  32  store data, lane-replicated
- dbus_rdata_i  in  32  read data
- dbus_ack_i  in  1  transaction complete
- bus_err_o  out  1  timeout pulse (MEM_TIMEOUT_EN only)

Behaviour:
- Reset, asynchronous on rst low:
  - State is IDLE.
  - All dbus_* outputs are 0; rdata_q is 0.
  - All outputs are 0 or disabled, including stallreq_o, misalign_o and bus_err_o.
  - A reset during BUSY drops dbus_req_o immediately and cancels the pending load write-back.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. All other aluop values are non-memory.
- Non-memory op: outputs equal the inputs combinationally; stallreq_o is 0.
- Lane mapping is big-endian:
  - Byte: addr[1:0]=00 selects sel 1000 / bits 31:24, up to 11 selecting sel 0001 / bits 7:0.
  - Half: addr[1]=0 selects 1100; addr[1]=1 selects 0011.
  - Word: 1111.
- Store data is replicated: byte across all four lanes; half across both halves.
- Load formatting: LB and LH sign-extend; LBU and LHU zero-extend.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - No bus request is issued and there is no stall.
  - wreg_o is 0 and misalign_o is 1 for that cycle.
  - All other outputs pass through.
- FSM states: IDLE, BUSY, DONE.
- IDLE with an aligned memory op:
  - stallreq_o is 1 combinationally.
  - At the next edge, dbus_req/we/addr/sel/wdata are registered and the state moves to BUSY.
- BUSY:
  - stallreq_o is 1.
  - dbus_* outputs hold stable until ack.
  - dbus_ack_i is sampled at posedge. On ack: dbus_req_o goes to 0, rdata_q captures formatted dbus_rdata_i, and the state moves to DONE.
- DONE:
  - stallreq_o is 0.
  - Load: wdata_o is rdata_q and wreg_o is wreg_i.
  - Store: wreg_o is 0.
  - Leaves to IDLE when stall[4]==`NoStop; otherwise holds DONE with outputs stable.
- An ack seen in IDLE or DONE is ignored.
- Latency: the earliest ack is one cycle after req. Minimum memory-op occupancy is 3 cycles (IDLE, BUSY, DONE).
- The stall input affects only the DONE exit. Inputs are guaranteed stable by upstream stalling while stallreq_o is 1.
- HI/LO signals always pass through unchanged.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without ack: dbus_req_o goes to 0, rdata_q to 0, bus_err_o is 1 for one cycle, and the state moves to DONE with wreg_o forced to 0.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely, there is no counter, and bus_err_o is tied to 0.

Test Plan:
- ADDU passthrough: wd_i=5, wdata_i=0x1234 -> same cycle wd_o=5, wdata_o=0x1234, stallreq_o=0, dbus_req_o=0.
- LB at addr 0x103 with ack after 2 BUSY cycles and rdata 0x112233F0:
  - dbus_addr_o=0x100, sel=0001, stallreq_o high for 3 cycles.
  - DONE gives wdata_o=0xFFFFFFF0, wreg_o=1.
- SH at addr 0x202 with reg2_i=0xAAAABEEF -> sel=0011, we=1, dbus_wdata_o=0xBEEFBEEF; after ack wreg_o=0.
- LW at addr 0x301 -> misalign_o=1, wreg_o=0, no dbus_req_o, stallreq_o=0.
- Reset low during BUSY -> dbus_req_o=0 immediately; after release, state is IDLE and a stray ack produces no write-back.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> bus_err_o pulses after 4 BUSY cycles, wreg_o=0, stallreq_o drops.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM stage of the five-stage pipeline.
// Non-memory ops pass straight through to MEM/WB. Loads and stores run a
// req/ack data-bus transaction (IDLE -> BUSY -> DONE) and hold the pipeline
// through stallreq_o until the transaction completes. Lane mapping is big-endian.
// Optional feature macro: MEM_TIMEOUT_EN aborts a BUSY transaction after
// TIMEOUT_CYCLES cycles without ack and pulses bus_err_o.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [5:0]  stall,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        bus_err_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic       NO_STOP    = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Big-endian byte-lane select for the access size and address offset.
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
    logic [3:0] s;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        case (a)
          2'b00:   s = 4'b1000;
          2'b01:   s = 4'b0100;
          2'b10:   s = 4'b0010;
          2'b11:   s = 4'b0001;
          default: s = 4'b0000;
        endcase
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: s = a[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP:             s = 4'b1111;
      default:                          s = 4'b0000;
    endcase
    return s;
  endfunction

  // Store data replicated so every selected lane carries the operand.
  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      EXE_SB_OP: r = {4{d[7:0]}};
      EXE_SH_OP: r = {2{d[15:0]}};
      default:   r = d;
    endcase
    return r;
  endfunction

  // Extract the addressed lane from bus read data and extend it to 32 bits.
  function automatic logic [31:0] load_fmt(input logic [7:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = rd[31:24];
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      2'b11:   b = rd[7:0];
      default: b = 8'h00;
    endcase
    h = a[1] ? rd[15:0] : rd[31:16];
    case (op)
      EXE_LB_OP:  r = {{24{b[7]}}, b};
      EXE_LBU_OP: r = {24'h000000, b};
      EXE_LH_OP:  r = {{16{h[15]}}, h};
      EXE_LHU_OP: r = {16'h0000, h};
      EXE_LW_OP:  r = rd;
      default:    r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t      r_state;
  logic        r_dbus_req;
  logic        r_dbus_we;
  logic [31:0] r_dbus_addr;
  logic [3:0]  r_dbus_sel;
  logic [31:0] r_dbus_wdata;
  logic [31:0] r_rdata_q;
  logic        r_is_load;
  logic        r_abort;

  logic w_is_mem;
  logic w_is_load;
  logic w_misalign;
  logic w_unused_stall;

  // Only stall[4] (MEM/WB hold) affects this stage.
  assign w_unused_stall = ^{stall[5], stall[3:0]};

  assign w_is_load = (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LBU_OP) ||
                     (aluop_i == EXE_LH_OP) || (aluop_i == EXE_LHU_OP) ||
                     (aluop_i == EXE_LW_OP);
  assign w_is_mem  = w_is_load || (aluop_i == EXE_SB_OP) ||
                     (aluop_i == EXE_SH_OP) || (aluop_i == EXE_SW_OP);
  assign w_misalign = (((aluop_i == EXE_LH_OP) || (aluop_i == EXE_LHU_OP) ||
                        (aluop_i == EXE_SH_OP)) && mem_addr_i[0]) ||
                      (((aluop_i == EXE_LW_OP) || (aluop_i == EXE_SW_OP)) &&
                        (mem_addr_i[1:0] != 2'b00));

  assign dbus_req_o   = r_dbus_req;
  assign dbus_we_o    = r_dbus_we;
  assign dbus_addr_o  = r_dbus_addr;
  assign dbus_sel_o   = r_dbus_sel;
  assign dbus_wdata_o = r_dbus_wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  assign bus_err_o = r_bus_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 32'd0);
  assign bus_err_o = 1'b0;
`endif

  // Write-back bundle: pass-through, misalign squash, stall request, load result in DONE.
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    hi_o       = hi_i;
    lo_o       = lo_i;
    whilo_o    = whilo_i;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem && w_misalign) begin
          wreg_o     = 1'b0;
          misalign_o = 1'b1;
        end else if (w_is_mem) begin
          wreg_o     = 1'b0;
          stallreq_o = 1'b1;
        end else begin
          wreg_o = wreg_i;
        end
      end
      S_BUSY: begin
        wreg_o     = 1'b0;
        stallreq_o = 1'b1;
      end
      S_DONE: begin
        if (r_is_load) begin
          wdata_o = r_rdata_q;
          wreg_o  = wreg_i & ~r_abort;
        end else begin
          wreg_o = 1'b0;
        end
      end
      default: begin
        wreg_o = 1'b0;
      end
    endcase
  end

  // Bus transaction FSM with registered bus outputs and captured load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_dbus_req   <= 1'b0;
      r_dbus_we    <= 1'b0;
      r_dbus_addr  <= 32'h0000_0000;
      r_dbus_sel   <= 4'b0000;
      r_dbus_wdata <= 32'h0000_0000;
      r_rdata_q    <= 32'h0000_0000;
      r_is_load    <= 1'b0;
      r_abort      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt        <= '0;
      r_bus_err    <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      r_bus_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_is_mem && !w_misalign) begin
            r_dbus_req   <= 1'b1;
            r_dbus_we    <= ~w_is_load;
            r_dbus_addr  <= {mem_addr_i[31:2], 2'b00};
            r_dbus_sel   <= lane_sel(aluop_i, mem_addr_i[1:0]);
            r_dbus_wdata <= store_data(aluop_i, reg2_i);
            r_is_load    <= w_is_load;
            r_abort      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt        <= '0;
`endif
            r_state      <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (dbus_ack_i) begin
            r_dbus_req <= 1'b0;
            r_rdata_q  <= load_fmt(aluop_i, mem_addr_i[1:0], dbus_rdata_i);
            r_state    <= S_DONE;
`ifdef MEM_TIMEOUT_EN
          end else if (r_cnt == CNT_LAST) begin
            r_dbus_req <= 1'b0;
            r_rdata_q  <= 32'h0000_0000;
            r_bus_err  <= 1'b1;
            r_abort    <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          end else begin
            r_state <= S_BUSY;
          end
`endif
        end
        S_DONE: begin
          if (stall[4] == NO_STOP) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_dbus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_LB   = 8'hE0;
  localparam logic [7:0] OP_LBU  = 8'hE4;
  localparam logic [7:0] OP_LH   = 8'hE1;
  localparam logic [7:0] OP_LHU  = 8'hE5;
  localparam logic [7:0] OP_LW   = 8'hE3;
  localparam logic [7:0] OP_SB   = 8'hE8;
  localparam logic [7:0] OP_SH   = 8'hE9;
  localparam logic [7:0] OP_SW   = 8'hEB;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic [5:0]  stall;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        whilo_o, stallreq_o, misalign_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o, dbus_rdata_i;
  logic        dbus_ack_i, bus_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i),
    .whilo_i(whilo_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .stall(stall),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
    .whilo_o(whilo_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .bus_err_o(bus_err_o)
  );

  task automatic set_nop();
    aluop_i = OP_NOP; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
    mem_addr_i = 32'h0; reg2_i = 32'h0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
    whilo_i = 1'b0; hi_i = 32'h0; lo_i = 32'h0; stall = 6'b000000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%h want=0", dbus_req_o); end
    total++; if (dbus_we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%h want=0", dbus_we_o); end
    total++; if (dbus_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", dbus_addr_o); end
    total++; if (dbus_sel_o !== 4'h0) begin bad++; $display("FAIL rst_sel got=%h want=0", dbus_sel_o); end
    total++; if (dbus_wdata_o !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", dbus_wdata_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stallreq got=%h want=0", stallreq_o); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%h want=0", misalign_o); end
    total++; if (bus_err_o !== 1'b0) begin bad++; $display("FAIL rst_bus_err got=%h want=0", bus_err_o); end
    total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL rst_wreg got=%h want=0", wreg_o); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    aluop_i = OP_ADDU; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h0000_1234;
    hi_i = 32'hA5A5_0001; lo_i = 32'h5A5A_0002; whilo_i = 1'b1;
    #1;
    total++; if (wd_o !== 5'd5) begin bad++; $display("FAIL pt_wd got=%h want=5", wd_o); end
    total++; if (wdata_o !== 32'h0000_1234) begin bad++; $display("FAIL pt_wdata got=%h want=00001234", wdata_o); end
    total++; if (wreg_o !== 1'b1) begin bad++; $display("FAIL pt_wreg got=%h want=1", wreg_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL pt_stallreq got=%h want=0", stallreq_o); end
    total++; if (hi_o !== 32'hA5A5_0001) begin bad++; $display("FAIL pt_hi got=%h want=a5a50001", hi_o); end
    total++; if (lo_o !== 32'h5A5A_0002) begin bad++; $display("FAIL pt_lo got=%h want=5a5a0002", lo_o); end
    total++; if (whilo_o !== 1'b1) begin bad++; $display("FAIL pt_whilo got=%h want=1", whilo_o); end
    @(posedge clk); #1;
    total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL pt_req got=%h want=0", dbus_req_o); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_load_byte();
    int n_stall;
    n_stall = 0;
    @(negedge clk);
    aluop_i = OP_LB; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h0000_5555;
    mem_addr_i = 32'h0000_0103; dbus_rdata_i = 32'h1122_33F0;
    #1;
    if (stallreq_o === 1'b1) n_stall++;
    total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL lb_idle_req got=%h want=0", dbus_req_o); end
    @(posedge clk); #1;
    total++; if (dbus_req_o !== 1'b1) begin bad++; $display("FAIL lb_req got=%h want=1", dbus_req_o); end
    total++; if (dbus_addr_o !== 32'h0000_0100) begin bad++; $display("FAIL lb_addr got=%h want=00000100", dbus_addr_o); end
    total++; if (dbus_sel_o !== 4'b0001) begin bad++; $display("FAIL lb_sel got=%b want=0001", dbus_sel_o); end
    total++; if (dbus_we_o !== 1'b0) begin bad++; $display("FAIL lb_we got=%h want=0", dbus_we_o); end
    @(negedge clk);
    if (stallreq_o === 1'b1) n_stall++;
    @(negedge clk);
    if (stallreq_o === 1'b1) n_stall++;
    dbus_ack_i = 1'b1;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    total++; if (n_stall != 3) begin bad++; $display("FAIL lb_stall_cycles got=%0d want=3", n_stall); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL lb_done_stallreq got=%h want=0", stallreq_o); end
    total++; if (wdata_o !== 32'hFFFF_FFF0) begin bad++; $display("FAIL lb_wdata got=%h want=fffffff0", wdata_o); end
    total++; if (wreg_o !== 1'b1) begin bad++; $display("FAIL lb_wreg got=%h want=1", wreg_o); end
    total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL lb_done_req got=%h want=0", dbus_req_o); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_load_variants();
    logic [7:0]  ops  [5] = '{OP_LBU, OP_LB, OP_LH, OP_LHU, OP_LW};
    logic [31:0] adr  [5] = '{32'h100, 32'h101, 32'h102, 32'h100, 32'h104};
    logic [31:0] rd   [5] = '{32'h8011_2233, 32'h1180_2233, 32'h1234_8001, 32'h8001_1234, 32'hDEAD_BEEF};
    logic [3:0]  sel  [5] = '{4'b1000, 4'b0100, 4'b0011, 4'b1100, 4'b1111};
    logic [31:0] exp  [5] = '{32'h0000_0080, 32'hFFFF_FF80, 32'hFFFF_8001, 32'h0000_8001, 32'hDEAD_BEEF};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      aluop_i = ops[i]; mem_addr_i = adr[i]; dbus_rdata_i = rd[i]; wreg_i = 1'b1; wd_i = 5'd3;
      @(posedge clk); #1;
      total++; if (dbus_sel_o !== sel[i]) begin bad++; $display("FAIL ld%0d_sel got=%b want=%b", i, dbus_sel_o, sel[i]); end
      total++; if (dbus_addr_o !== {adr[i][31:2], 2'b00}) begin bad++; $display("FAIL ld%0d_addr got=%h", i, dbus_addr_o); end
      @(negedge clk);
      dbus_ack_i = 1'b1;
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;
      total++; if (wdata_o !== exp[i]) begin bad++; $display("FAIL ld%0d_wdata got=%h want=%h", i, wdata_o, exp[i]); end
      total++; if (wreg_o !== 1'b1) begin bad++; $display("FAIL ld%0d_wreg got=%h want=1", i, wreg_o); end
      @(negedge clk);
      set_nop();
    end
  endtask

  task automatic test_store();
    logic [7:0]  ops [3] = '{OP_SH, OP_SB, OP_SW};
    logic [31:0] adr [3] = '{32'h202, 32'h201, 32'h208};
    logic [31:0] dat [3] = '{32'hAAAA_BEEF, 32'h1234_565A, 32'hCAFE_F00D};
    logic [3:0]  sel [3] = '{4'b0011, 4'b0100, 4'b1111};
    logic [31:0] bus [3] = '{32'hBEEF_BEEF, 32'h5A5A_5A5A, 32'hCAFE_F00D};
    logic [31:0] wa  [3] = '{32'h200, 32'h200, 32'h208};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      aluop_i = ops[i]; mem_addr_i = adr[i]; reg2_i = dat[i]; wreg_i = 1'b1;
      @(posedge clk); #1;
      total++; if (dbus_sel_o !== sel[i]) begin bad++; $display("FAIL st%0d_sel got=%b want=%b", i, dbus_sel_o, sel[i]); end
      total++; if (dbus_we_o !== 1'b1) begin bad++; $display("FAIL st%0d_we got=%h want=1", i, dbus_we_o); end
      total++; if (dbus_wdata_o !== bus[i]) begin bad++; $display("FAIL st%0d_wdata got=%h want=%h", i, dbus_wdata_o, bus[i]); end
      total++; if (dbus_addr_o !== wa[i]) begin bad++; $display("FAIL st%0d_addr got=%h want=%h", i, dbus_addr_o, wa[i]); end
      @(negedge clk);
      dbus_ack_i = 1'b1;
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;
      total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL st%0d_wreg got=%h want=0", i, wreg_o); end
      total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL st%0d_stallreq got=%h want=0", i, stallreq_o); end
      @(negedge clk);
      set_nop();
    end
  endtask

  task automatic test_misalign();
    logic [7:0]  ops [4] = '{OP_LW, OP_SH, OP_LHU, OP_SW};
    logic [31:0] adr [4] = '{32'h301, 32'h203, 32'h105, 32'h302};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      aluop_i = ops[i]; mem_addr_i = adr[i]; wreg_i = 1'b1; wdata_i = 32'h0000_0077; wd_i = 5'd9;
      #1;
      total++; if (misalign_o !== 1'b1) begin bad++; $display("FAIL mis%0d_flag got=%h want=1", i, misalign_o); end
      total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL mis%0d_wreg got=%h want=0", i, wreg_o); end
      total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL mis%0d_stallreq got=%h want=0", i, stallreq_o); end
      total++; if (wdata_o !== 32'h0000_0077) begin bad++; $display("FAIL mis%0d_wdata got=%h want=77", i, wdata_o); end
      @(posedge clk); #1;
      total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL mis%0d_req got=%h want=0", i, dbus_req_o); end
      @(negedge clk);
      set_nop();
      #1;
      total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis%0d_clear got=%h want=0", i, misalign_o); end
    end
  endtask

  task automatic test_done_hold();
    @(negedge clk);
    aluop_i = OP_LW; mem_addr_i = 32'h10C; wreg_i = 1'b1; wdata_i = 32'h0000_00AA;
    dbus_rdata_i = 32'h0102_0304; stall = 6'b010000;
    @(posedge clk);
    @(negedge clk);
    dbus_ack_i = 1'b1;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (wdata_o !== 32'h0102_0304) begin bad++; $display("FAIL hold%0d_wdata got=%h want=01020304", k, wdata_o); end
      total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL hold%0d_stallreq got=%h want=0", k, stallreq_o); end
    end
    @(negedge clk);
    stall = 6'b000000;
    @(posedge clk); #1;
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL hold_exit_idle got=%h want=1", stallreq_o); end
    total++; if (wdata_o !== 32'h0000_00AA) begin bad++; $display("FAIL hold_exit_wdata got=%h want=aa", wdata_o); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    aluop_i = OP_LW; mem_addr_i = 32'h400; wreg_i = 1'b1; wd_i = 5'd4;
    @(posedge clk); #1;
    total++; if (dbus_req_o !== 1'b1) begin bad++; $display("FAIL rb_req_before got=%h want=1", dbus_req_o); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL rb_req_async got=%h want=0", dbus_req_o); end
    total++; if (dbus_sel_o !== 4'h0) begin bad++; $display("FAIL rb_sel_async got=%h want=0", dbus_sel_o); end
    set_nop();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL rb%0d_wreg got=%h want=0", k, wreg_o); end
      total++; if (wdata_o !== 32'h0) begin bad++; $display("FAIL rb%0d_wdata got=%h want=0", k, wdata_o); end
      total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL rb%0d_req got=%h want=0", k, dbus_req_o); end
      @(posedge clk); #1;
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int busy;
    @(negedge clk);
    aluop_i = OP_LW; mem_addr_i = 32'h500; wreg_i = 1'b1; dbus_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    busy = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus_err_o === 1'b1) break;
      busy++;
    end
    total++; if (busy != 4) begin bad++; $display("FAIL to_busy_cycles got=%0d want=4", busy); end
    total++; if (bus_err_o !== 1'b1) begin bad++; $display("FAIL to_bus_err got=%h want=1", bus_err_o); end
    total++; if (wreg_o !== 1'b0) begin bad++; $display("FAIL to_wreg got=%h want=0", wreg_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL to_stallreq got=%h want=0", stallreq_o); end
    total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL to_req got=%h want=0", dbus_req_o); end
    @(negedge clk);
    set_nop();
    @(posedge clk); #1;
    total++; if (bus_err_o !== 1'b0) begin bad++; $display("FAIL to_pulse_len got=%h want=0", bus_err_o); end
  endtask
`else
  task automatic test_timeout();
    @(negedge clk);
    aluop_i = OP_LW; mem_addr_i = 32'h500; wreg_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    total++; if (bus_err_o !== 1'b0) begin bad++; $display("FAIL nto_bus_err got=%h want=0", bus_err_o); end
    total++; if (dbus_req_o !== 1'b1) begin bad++; $display("FAIL nto_req_held got=%h want=1", dbus_req_o); end
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL nto_stallreq got=%h want=1", stallreq_o); end
    @(negedge clk);
    dbus_ack_i = 1'b1;
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    @(negedge clk);
    set_nop();
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte();
    test_load_variants();
    test_store();
    test_misalign();
    test_done_hold();
    test_reset_busy();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
